mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 8, address width; DATA_W, default 8, data width; LDR_MAX_BURST, default 16, max consecutive loader grants while CPU waits.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- cpu_req  input  1  CPU access request, held until cpu_ack
- cpu_we  input  1  CPU write(1)/read(0)
- cpu_addr  input  ADDR_W  CPU address
- cpu_wdata  input  DATA_W  CPU write data
- cpu_ack  output  1  one-cycle CPU completion pulse
- cpu_rdata  output  DATA_W  CPU read data, valid when cpu_ack=1
- ldr_req  input  1  loader request, held until ldr_ack
- ldr_we  input  1  loader write(1)/read(0)
- ldr_addr  input  ADDR_W  loader address
- ldr_wdata  input  DATA_W  loader write data
- ldr_ack  output  1  one-cycle loader completion pulse
- ldr_rdata  output  DATA_W  loader read data, valid when ldr_ack=1
- mem_rd  output  1  memory read strobe
- mem_wr  output  1  memory write strobe
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid the cycle mem_rd=1
- busy  output  1  high in any state other than IDLE
REQ-003 Clock/reset SHALL be exactly as decided: one clock; reset is asynchronous and active-low.

Function
REQ-004 SHALL implement FSM states IDLE, CPU_ACC, LDR_ACC, DONE.
REQ-005 IDLE: if ldr_req and not (cpu_req and burst_cnt==LDR_MAX_BURST) -> LDR_ACC; else if cpu_req -> CPU_ACC; else stay.
REQ-006 On leaving IDLE, SHALL latch the winner's we, addr, wdata and an owner bit; requester changes after grant are ignored.
REQ-007 In CPU_ACC/LDR_ACC, exactly one of mem_rd/mem_wr SHALL be high (per latched we) for exactly one cycle, with mem_addr/mem_wdata from latched values; next state DONE.
REQ-008 In *_ACC with we=0, SHALL register mem_rdata into the owner's rdata register at the end of that cycle.
REQ-009 DONE: owner's ack SHALL be high for exactly one cycle; next state IDLE unconditionally; earliest re-grant one cycle after ack (3 cycles per access).
REQ-010 Request-to-ack latency SHALL be 2 cycles after the IDLE cycle sampling the request.
REQ-011 burst_cnt (width clog2(LDR_MAX_BURST+1)): +1 per loader grant while cpu_req=1, saturating at LDR_MAX_BURST; cleared on CPU grant or in any IDLE cycle with cpu_req=0.
REQ-012 Both requests in same IDLE cycle: loader wins unless burst_cnt==LDR_MAX_BURST, then CPU wins.
REQ-013 mem_addr/mem_wdata SHALL hold last latched values outside *_ACC; strobes low outside *_ACC.
REQ-014 cpu_rdata/ldr_rdata SHALL hold value until next read completion for that requester; unchanged on writes.
REQ-015 Request dropped before its ack: in-flight access SHALL still complete and pulse ack.
REQ-016 Never more than one ack high per cycle; never both strobes high.

Reset
REQ-017 rst_n=0 SHALL immediately force state IDLE, burst_cnt 0, all strobes/acks/busy 0, mem_addr/mem_wdata/rdata regs 0, independent of clk.
REQ-018 Reset mid-access SHALL abort it with no ack; no strobe on first edge after deassertion unless re-requested.

Structure
REQ-019 State encoding, state typedef and LDR_MAX_BURST default SHALL live in the shared processor package.
REQ-020 Arbitration decision (REQ-005/011/012) SHALL be a sub-module, mem_arb_priority; FSM and datapath latches stay in mem_arbiter.

Verification
REQ-021 CPU read addr 0x12, mem returns 0xA5 -> mem_rd 1 cycle with mem_addr=0x12; cpu_ack 2 cycles after request sampled, cpu_rdata=0xA5.
REQ-022 Loader write addr 0x40 data 0x3C concurrent with CPU read -> loader served first (mem_wr, 0x40/0x3C), CPU served next; acks 3 cycles apart.
REQ-023 ldr_req held high with LDR_MAX_BURST=16, cpu_req high -> exactly 16 loader grants then one CPU grant; burst_cnt returns to 0.
REQ-024 rst_n low during CPU_ACC -> strobes/acks drop immediately, no cpu_ack; after release with no requests, busy stays 0.
REQ-025 cpu_req dropped in CPU_ACC -> cpu_ack still pulses once in DONE; no second access.
REQ-026 Random traffic assertion check: never mem_rd&mem_wr, never cpu_ack&ldr_ack, every ack exactly 1 cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CPU/loader memory arbiter.
package mem_arbiter_pkg;

  // Default cap on back-to-back loader grants while the CPU is waiting.
  localparam int LDR_MAX_BURST_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    LDR_ACC = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_priority.sv
// Grant decision between CPU and loader, with the loader burst limiter.
// The loader normally wins; after LDR_MAX_BURST loader grants taken while
// the CPU was waiting, the CPU gets the next slot.
module mem_arb_priority
  import mem_arbiter_pkg::*;
#(
  parameter int LDR_MAX_BURST = LDR_MAX_BURST_DEF,
  localparam int CNT_W = $clog2(LDR_MAX_BURST + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic cpu_req,
  input  logic ldr_req,
  output logic grant_cpu,
  output logic grant_ldr
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(LDR_MAX_BURST);

  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             at_max;

  // Grant selection and burst counter next value; only IDLE cycles matter.
  always_comb begin
    at_max      = (burst_cnt_q == MAX_CNT);
    grant_ldr   = idle && ldr_req && !(cpu_req && at_max);
    grant_cpu   = idle && cpu_req && !grant_ldr;
    burst_cnt_d = burst_cnt_q;
    if (idle) begin
      if (!cpu_req || grant_cpu) begin
        burst_cnt_d = '0;
      end else if (grant_ldr && !at_max) begin
        burst_cnt_d = burst_cnt_q + CNT_W'(1);
      end
    end
  end

  // Burst counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) burst_cnt_q <= '0;
    else        burst_cnt_q <= burst_cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU, loader) single-port memory arbiter.
// Each access takes IDLE -> *_ACC (one strobe cycle) -> DONE (ack) -> IDLE.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 8,
  parameter int LDR_MAX_BURST = LDR_MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Request captured at grant; requester changes afterwards are ignored.
  typedef struct packed {
    owner_e            owner;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  arb_state_e        state_q, state_d;
  acc_t              lat_q, lat_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
  logic              idle, in_acc, grant_cpu, grant_ldr;

  assign idle = (state_q == IDLE);

  mem_arb_priority #(
    .LDR_MAX_BURST(LDR_MAX_BURST)
  ) u_prio (
    .clk       (clk),
    .rst_n     (rst_n),
    .idle      (idle),
    .cpu_req   (cpu_req),
    .ldr_req   (ldr_req),
    .grant_cpu (grant_cpu),
    .grant_ldr (grant_ldr)
  );

  // Next state, grant latching and read-data capture.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_ldr) begin
          state_d     = LDR_ACC;
          lat_d.owner = OWN_LDR;
          lat_d.we    = ldr_we;
          lat_d.addr  = ldr_addr;
          lat_d.wdata = ldr_wdata;
        end else if (grant_cpu) begin
          state_d     = CPU_ACC;
          lat_d.owner = OWN_CPU;
          lat_d.we    = cpu_we;
          lat_d.addr  = cpu_addr;
          lat_d.wdata = cpu_wdata;
        end
      end
      CPU_ACC, LDR_ACC: begin
        state_d = DONE;
        if (!lat_q.we) begin
          if (lat_q.owner == OWN_LDR) ldr_rdata_d = mem_rdata;
          else                        cpu_rdata_d = mem_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  // Outputs decode straight from state so reset clears them at once.
  assign in_acc    = (state_q == CPU_ACC) || (state_q == LDR_ACC);
  assign mem_rd    = in_acc && !lat_q.we;
  assign mem_wr    = in_acc &&  lat_q.we;
  assign mem_addr  = lat_q.addr;
  assign mem_wdata = lat_q.wdata;
  assign cpu_ack   = (state_q == DONE) && (lat_q.owner == OWN_CPU);
  assign ldr_ack   = (state_q == DONE) && (lat_q.owner == OWN_LDR);
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;
  assign busy      = !idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed corner sequences and
// random traffic against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int MAXB = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we, ldr_req, ldr_we;
  logic [AW-1:0] cpu_addr, ldr_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, ldr_wdata, mem_wdata, mem_rdata;
  logic [DW-1:0] cpu_rdata, ldr_rdata;
  logic          cpu_ack, ldr_ack, mem_rd, mem_wr, busy;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LDR_MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Simple memory device: combinational read, write on the rising edge.
  logic [DW-1:0] tbmem [0:255];
  assign mem_rdata = tbmem[mem_addr];
  always @(posedge clk) if (mem_wr) tbmem[mem_addr] <= mem_wdata;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_cpu(input logic r, input logic we, input logic [7:0] a, input logic [7:0] d);
    cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_ldr(input logic r, input logic we, input logic [7:0] a, input logic [7:0] d);
    ldr_req = r; ldr_we = we; ldr_addr = a; ldr_wdata = d;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Single-requester transactions with hand-computed expected read data.
  typedef struct {
    bit         is_ldr;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    bit         pre;
    logic [7:0] pval;
    logic [7:0] exp_cpu_rd;
    logic [7:0] exp_ldr_rd;
  } vec_t;

  vec_t vt [6];

  task automatic do_vec(input vec_t v, input int idx);
    string s;
    s = $sformatf("vec%0d", idx);
    @(negedge clk);
    if (v.pre) tbmem[v.addr] <= v.pval;
    if (v.is_ldr) set_ldr(1'b1, v.we, v.addr, v.wdata);
    else          set_cpu(1'b1, v.we, v.addr, v.wdata);
    @(negedge clk);
    chk({s, "_rd"},   32'(mem_rd), 32'(!v.we));
    chk({s, "_wr"},   32'(mem_wr), 32'(v.we));
    chk({s, "_addr"}, 32'(mem_addr), 32'(v.addr));
    if (v.we) chk({s, "_wdata"}, 32'(mem_wdata), 32'(v.wdata));
    @(negedge clk);
    chk({s, "_cack"},  32'(cpu_ack), 32'(!v.is_ldr));
    chk({s, "_lack"},  32'(ldr_ack), 32'(v.is_ldr));
    chk({s, "_crd"},   32'(cpu_rdata), 32'(v.exp_cpu_rd));
    chk({s, "_lrd"},   32'(ldr_rdata), 32'(v.exp_ldr_rd));
    if (v.is_ldr) ldr_req = 1'b0; else cpu_req = 1'b0;
    @(negedge clk);
    chk({s, "_acks_low"}, 32'({cpu_ack, ldr_ack, mem_rd, mem_wr}), 32'(0));
    chk({s, "_idle"},     32'(busy), 32'(0));
    chk({s, "_hold"},     32'(mem_addr), 32'(v.addr));
  endtask

  // Random-phase reference state.
  int         wins, prev_grant, cnt, lacks;
  bit         busy_prev, exp_strobe, exp_c, exp_l;
  logic [7:0] c_exp_rd, l_exp_rd, c_rd_model, l_rd_model;
  int         cwait, lwait;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0, 0, 8'h12, 8'h00, 1, 8'hA5, 8'hA5, 8'h00};
    vt[1] = '{1, 0, 8'h34, 8'h99, 1, 8'h5A, 8'hA5, 8'h5A};
    vt[2] = '{0, 1, 8'h40, 8'h3C, 0, 8'h00, 8'hA5, 8'h5A};
    vt[3] = '{1, 1, 8'h7F, 8'hC3, 0, 8'h00, 8'hA5, 8'h5A};
    vt[4] = '{0, 0, 8'h40, 8'h00, 0, 8'h00, 8'h3C, 8'h5A};
    vt[5] = '{1, 0, 8'h7F, 8'h00, 0, 8'h00, 8'h3C, 8'hC3};

    for (int i = 0; i < 256; i++) tbmem[i] <= 8'(i * 7 + 3);
    rst_n = 1'b0;
    set_cpu(0, 0, 0, 0);
    set_ldr(0, 0, 0, 0);
    #1;
    chk("rst_strobes", 32'({mem_rd, mem_wr}), 32'(0));
    chk("rst_acks",    32'({cpu_ack, ldr_ack}), 32'(0));
    chk("rst_busy",    32'(busy), 32'(0));
    chk("rst_addr",    32'({mem_addr, mem_wdata}), 32'(0));
    chk("rst_rdata",   32'({cpu_rdata, ldr_rdata}), 32'(0));
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(1);

    // Vector table.
    for (int i = 0; i < 6; i++) do_vec(vt[i], i);

    // Loader write concurrent with CPU read: loader first, acks 3 apart.
    @(negedge clk);
    tbmem[8'h20] <= 8'h66;
    set_ldr(1, 1, 8'h40, 8'h3C);
    set_cpu(1, 0, 8'h20, 8'h00);
    @(negedge clk);
    chk("both_first_wr",   32'({mem_wr, mem_rd}), 32'(2));
    chk("both_first_addr", 32'({mem_addr, mem_wdata}), 32'(16'h403C));
    @(negedge clk);
    chk("both_lack", 32'({ldr_ack, cpu_ack}), 32'(2));
    ldr_req = 1'b0;
    @(negedge clk);
    chk("both_gap", 32'({cpu_ack, ldr_ack, mem_rd, mem_wr}), 32'(0));
    chk("both_memwritten", 32'(tbmem[8'h40]), 32'(8'h3C));
    @(negedge clk);
    chk("both_second_rd",   32'({mem_rd, mem_wr}), 32'(2));
    chk("both_second_addr", 32'(mem_addr), 32'(8'h20));
    @(negedge clk);
    chk("both_cack",  32'({cpu_ack, ldr_ack}), 32'(2));
    chk("both_crd",   32'(cpu_rdata), 32'(8'h66));
    cpu_req = 1'b0;
    idle_cycles(2);

    // Loader held continuously with CPU waiting: exactly MAXB loader grants.
    @(negedge clk);
    set_ldr(1, 1, 8'h55, 8'h11);
    set_cpu(1, 0, 8'h56, 8'h00);
    lacks = 0;
    cnt   = 0;
    while (!cpu_ack && cnt < 200) begin
      @(negedge clk);
      if (ldr_ack) lacks++;
      cnt++;
    end
    chk("burst_cpu_served", 32'(cpu_ack), 32'(1));
    chk("burst_ldr_grants", 32'(lacks), 32'(MAXB));
    chk("burst_cnt_clear",  32'(dut.u_prio.burst_cnt_q), 32'(0));
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    idle_cycles(3);

    // CPU request dropped mid-access still completes once.
    @(negedge clk);
    set_cpu(1, 0, 8'h21, 8'h00);
    @(negedge clk);
    chk("drop_rd", 32'(mem_rd), 32'(1));
    cpu_req = 1'b0;
    @(negedge clk);
    chk("drop_ack", 32'(cpu_ack), 32'(1));
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cnt += int'(mem_rd | mem_wr | cpu_ack | ldr_ack);
    end
    chk("drop_no_second", 32'(cnt), 32'(0));

    // Reset during CPU_ACC aborts the access.
    @(negedge clk);
    set_cpu(1, 0, 8'h22, 8'h00);
    @(negedge clk);
    chk("rstmid_rd", 32'(mem_rd), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_strobe", 32'({mem_rd, mem_wr, cpu_ack, ldr_ack}), 32'(0));
    chk("rstmid_busy",   32'(busy), 32'(0));
    chk("rstmid_regs",   32'({mem_addr, cpu_rdata, ldr_rdata}), 32'(0));
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cnt += int'(busy | mem_rd | mem_wr | cpu_ack | ldr_ack);
    end
    chk("rstmid_quiet", 32'(cnt), 32'(0));

    // Random traffic against the transaction-level model.
    wins = 0; prev_grant = 0; busy_prev = 1'b0;
    c_rd_model = 8'h00; l_rd_model = 8'h00;
    c_exp_rd = 8'h00; l_exp_rd = 8'h00;
    cwait = 0; lwait = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      exp_c = (prev_grant == 1);
      exp_l = (prev_grant == 2);
      chk("rnd_strobe_excl", 32'(mem_rd & mem_wr), 32'(0));
      chk("rnd_ack_excl",    32'(cpu_ack & ldr_ack), 32'(0));
      chk("rnd_cack",        32'(cpu_ack), 32'(exp_c));
      chk("rnd_lack",        32'(ldr_ack), 32'(exp_l));
      if (exp_c && !cpu_we) c_rd_model = c_exp_rd;
      if (exp_l && !ldr_we) l_rd_model = l_exp_rd;
      chk("rnd_crd", 32'(cpu_rdata), 32'(c_rd_model));
      chk("rnd_lrd", 32'(ldr_rdata), 32'(l_rd_model));

      exp_strobe = !busy_prev && (cpu_req || ldr_req);
      prev_grant = 0;
      if (exp_strobe) begin
        if (!cpu_req) begin
          prev_grant = 2; wins = 0;
        end else if (ldr_req && wins < MAXB) begin
          prev_grant = 2; wins++;
        end else begin
          prev_grant = 1; wins = 0;
        end
      end
      chk("rnd_strobe", 32'(mem_rd | mem_wr), 32'(exp_strobe));
      if (prev_grant == 1) begin
        chk("rnd_c_we",   32'(mem_wr), 32'(cpu_we));
        chk("rnd_c_addr", 32'(mem_addr), 32'(cpu_addr));
        if (cpu_we) chk("rnd_c_wdata", 32'(mem_wdata), 32'(cpu_wdata));
        else        c_exp_rd = tbmem[cpu_addr];
      end else if (prev_grant == 2) begin
        chk("rnd_l_we",   32'(mem_wr), 32'(ldr_we));
        chk("rnd_l_addr", 32'(mem_addr), 32'(ldr_addr));
        if (ldr_we) chk("rnd_l_wdata", 32'(mem_wdata), 32'(ldr_wdata));
        else        l_exp_rd = tbmem[ldr_addr];
      end
      busy_prev = exp_strobe || exp_c || exp_l;
      chk("rnd_busy", 32'(busy), 32'(busy_prev));

      // Requesters release on ack, then maybe issue a new request.
      if (exp_c) begin cpu_req = 1'b0; cwait = 0; end
      if (exp_l) begin ldr_req = 1'b0; lwait = 0; end
      if (cpu_req) cwait++;
      if (ldr_req) lwait++;
      if (cwait > 100 || lwait > 100) begin
        total++; bad++;
        $display("FAIL rnd_timeout: cwait=%0d lwait=%0d required<=100", cwait, lwait);
        cpu_req = 1'b0; ldr_req = 1'b0; cwait = 0; lwait = 0;
      end
      if (!cpu_req && $urandom_range(0, 3) == 0)
        set_cpu(1, 1'($urandom), 8'($urandom), 8'($urandom));
      if (!ldr_req && $urandom_range(0, 3) != 0)
        set_ldr(1, 1'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
